// File: rtl/updown_counter_bank.sv
// Bank of NCH independent up/down counters with sticky overflow/underflow flags.
// Optional snapshot capture FSM compiled in with UPDOWN_COUNTER_BANK_SNAPSHOT_EN.
module updown_counter_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       up_in,
  input  logic [NCH-1:0]       down_in,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic                 sat_mode,
  input  logic                 flag_clr,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       unf,
  input  logic                 snap_req,
  input  logic                 snap_ack,
  output logic                 snap_valid,
  output logic [NCH*WIDTH-1:0] snap_data
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Next count for one channel; at the bounds either wraps or saturates.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] cur,
    input logic             inc,
    input logic             dec,
    input logic             sat
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      if (&cur) nxt = sat ? cur : '0;
      else      nxt = cur + ONE;
    end else if (dec && !inc) begin
      if (cur == '0) nxt = sat ? cur : '1;
      else           nxt = cur - ONE;
    end
    return nxt;
  endfunction

  logic [NCH*WIDTH-1:0] w_out;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_cur = r_cnt;

    always_comb begin
      w_nxt = w_cur;
      if (load[i]) w_nxt = load_val[i*WIDTH +: WIDTH];
      else         w_nxt = f_step(w_cur, up_in[i], down_in[i], sat_mode);
    end

    // A load cycle never counts, so it can never raise a flag.
    assign w_ovf_set = ~load[i] & up_in[i] & ~down_in[i] & (&w_cur);
    assign w_unf_set = ~load[i] & down_in[i] & ~up_in[i] & ~(|w_cur);

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        r_cnt <= w_nxt;
        r_ovf <= w_ovf_set | (r_ovf & ~flag_clr);
        r_unf <= w_unf_set | (r_unf & ~flag_clr);
      end
    end

    assign w_out[i*WIDTH +: WIDTH] = r_cnt;
    assign ovf[i]                  = r_ovf;
    assign unf[i]                  = r_unf;
  end

  assign out = w_out;

`ifdef UPDOWN_COUNTER_BANK_SNAPSHOT_EN
  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} snap_state_t;

  snap_state_t          r_state;
  logic                 r_snap_valid;
  logic [NCH*WIDTH-1:0] r_snap_data;

  // Capture takes the counter value visible this cycle, before its update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_snap_valid <= 1'b0;
      r_snap_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            r_snap_data  <= w_out;
            r_state      <= S_HOLD;
            r_snap_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (snap_ack) begin
            r_state      <= S_IDLE;
            r_snap_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign snap_valid = r_snap_valid;
  assign snap_data  = r_snap_data;
`else
  logic w_unused_snap;
  assign w_unused_snap = snap_req ^ snap_ack;
  assign snap_valid    = 1'b0;
  assign snap_data     = '0;
`endif

endmodule

// File: tb/tb_updown_counter_bank.sv
// Directed bench for updown_counter_bank (NCH=2, WIDTH=4) with a queue scoreboard.
module tb_updown_counter_bank;
  localparam int NCH   = 2;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] up_in, down_in, load;
  logic [7:0] load_val;
  logic       sat_mode, flag_clr;
  logic [7:0] out;
  logic [1:0] ovf, unf;
  logic       snap_req, snap_ack, snap_valid;
  logic [7:0] snap_data;

  always #5 clk = ~clk;

  updown_counter_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .up_in(up_in), .down_in(down_in), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .flag_clr(flag_clr), .out(out),
    .ovf(ovf), .unf(unf), .snap_req(snap_req), .snap_ack(snap_ack),
    .snap_valid(snap_valid), .snap_data(snap_data)
  );

  typedef struct packed {
    logic [7:0] out;
    logic [1:0] ovf;
    logic [1:0] unf;
    logic       sv;
    logic [7:0] sd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  logic [3:0] m_cnt [2];
  logic [1:0] m_ovf, m_unf;
  logic       m_sv;
  logic [7:0] m_sd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step%0d observed=%0h expected=%0h", tag, stepn, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs now driven.
  task automatic model_push();
    exp_t       e;
    logic [3:0] nc [2];
    logic [1:0] no, nu;
    no = flag_clr ? 2'b00 : m_ovf;
    nu = flag_clr ? 2'b00 : m_unf;
    for (int i = 0; i < 2; i++) begin
      nc[i] = m_cnt[i];
      if (load[i]) begin
        nc[i] = load_val[i*4 +: 4];
      end else if (up_in[i] && !down_in[i]) begin
        if (m_cnt[i] == 4'hF) begin
          no[i] = 1'b1;
          nc[i] = sat_mode ? 4'hF : 4'h0;
        end else nc[i] = m_cnt[i] + 4'd1;
      end else if (down_in[i] && !up_in[i]) begin
        if (m_cnt[i] == 4'h0) begin
          nu[i] = 1'b1;
          nc[i] = sat_mode ? 4'h0 : 4'hF;
        end else nc[i] = m_cnt[i] - 4'd1;
      end
    end
`ifdef UPDOWN_COUNTER_BANK_SNAPSHOT_EN
    if (!m_sv) begin
      if (snap_req) begin
        m_sd = {m_cnt[1], m_cnt[0]};
        m_sv = 1'b1;
      end
    end else if (snap_ack) begin
      m_sv = 1'b0;
    end
`endif
    if (reset) begin
      nc[0] = '0; nc[1] = '0; no = '0; nu = '0; m_sv = 1'b0; m_sd = '0;
    end
    m_cnt[0] = nc[0];
    m_cnt[1] = nc[1];
    m_ovf    = no;
    m_unf    = nu;
    e.out = {nc[1], nc[0]};
    e.ovf = no;
    e.unf = nu;
    e.sv  = m_sv;
    e.sd  = m_sd;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    stepn++;
    e = sb.pop_front();
    chk("out", 32'(out), 32'(e.out));
    chk("ovf", 32'(ovf), 32'(e.ovf));
    chk("unf", 32'(unf), 32'(e.unf));
    chk("snap_valid", 32'(snap_valid), 32'(e.sv));
    chk("snap_data", 32'(snap_data), 32'(e.sd));
  endtask

  task automatic idle_inputs();
    reset = 0; up_in = 0; down_in = 0; load = 0; load_val = 0;
    flag_clr = 0; snap_req = 0; snap_ack = 0;
  endtask

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0; m_ovf = 0; m_unf = 0; m_sv = 0; m_sd = 0;
    idle_inputs();
    sat_mode = 0;
    @(negedge clk);

    // Reset overrides a simultaneous load
    reset = 1; load = 2'b11; load_val = 8'hA5; snap_req = 1;
    step();
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_flags", 32'({ovf, unf}), 32'h0);
    idle_inputs();

    // Count up three cycles on ch0, then both requests hold
    up_in = 2'b01;
    repeat (3) step();
    chk("up3_out", 32'(out), 32'h03);
    down_in = 2'b01;
    step();
    chk("hold_out", 32'(out), 32'h03);
    idle_inputs();

    // Wrap on increment at all-ones sets ovf; flag_clr clears it
    sat_mode = 0; load = 2'b01; load_val = 8'h0F;
    step();
    idle_inputs(); up_in = 2'b01;
    step();
    chk("wrap_out", 32'(out[3:0]), 32'h0);
    chk("wrap_ovf", 32'(ovf), 32'b01);
    idle_inputs(); flag_clr = 1;
    step();
    chk("clr_ovf", 32'(ovf), 32'b00);
    idle_inputs();

    // Saturating decrement at 0 on ch1; set beats same-cycle clear
    sat_mode = 1; down_in = 2'b10;
    repeat (2) step();
    chk("sat_dn_out", 32'(out[7:4]), 32'h0);
    chk("sat_dn_unf", 32'(unf), 32'b10);
    flag_clr = 1;
    step();
    chk("set_beats_clr", 32'(unf), 32'b10);
    idle_inputs();

    // Load wins over count and never flags, even at all-ones
    load = 2'b01; load_val = 8'h09; up_in = 2'b01;
    step();
    chk("load_pri", 32'(out[3:0]), 32'h9);
    chk("load_noflag", 32'(ovf), 32'b00);
    load_val = 8'h0F;
    step();
    load_val = 8'h03;
    step();
    chk("load_at_max", 32'({ovf, out[3:0]}), 32'h03);

    // Saturating increment at all-ones holds and flags
    load_val = 8'h0F;
    step();
    idle_inputs(); up_in = 2'b01;
    step();
    chk("sat_up", 32'({ovf, out[3:0]}), 32'h1F);

    // Wrapping decrement at 0
    idle_inputs(); sat_mode = 0; flag_clr = 1; down_in = 2'b10;
    step();
    chk("wrap_dn", 32'({unf, out[7:4]}), 32'h2F);
    idle_inputs();

    // Snapshot: capture, ignore second request, ack, ack in idle, reset in hold
    load = 2'b01; load_val = 8'h05;
    step();
    idle_inputs(); up_in = 2'b01; snap_req = 1;
    step();
`ifdef UPDOWN_COUNTER_BANK_SNAPSHOT_EN
    chk("snap_cap", 32'({snap_valid, snap_data[3:0], out[3:0]}), 32'h156);
`endif
    step();
    step();
`ifdef UPDOWN_COUNTER_BANK_SNAPSHOT_EN
    chk("snap_hold", 32'({snap_valid, snap_data[3:0], out[3:0]}), 32'h158);
`endif
    snap_req = 0; snap_ack = 1;
    step();
    chk("snap_ack", 32'(snap_valid), 32'h0);
    step();
    snap_ack = 0; snap_req = 1;
    step();
    snap_req = 0;
    step();
    reset = 1;
    step();
    chk("reset_hold", 32'({snap_valid, snap_data, out}), 32'h0);
    idle_inputs();
    step();

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
